// File: rtl/uart_tx_sink.sv
// uart_tx_sink: bench-side receiver for the SoC UART TX line.
// Synchronized input, mid-bit sampling, optional parity check.
module uart_tx_sink #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        busy_o,
  output logic [15:0] char_cnt_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      sh, sh_n;
  logic            par_bad, par_bad_n;
  logic            valid_n, ferr_n, perr_n;
  logic            data_ld;
  logic            tick;

  assign tick   = (cnt == '0);
  assign busy_o = (state != IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      par_bad      <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      char_cnt_o   <= '0;
    end else begin
      rx_m         <= rx_i;
      rx_s         <= rx_m;
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      par_bad      <= par_bad_n;
      valid_o      <= valid_n;
      frame_err_o  <= ferr_n;
      parity_err_o <= perr_n;
      if (data_ld)
        data_o <= sh;
      if (valid_n && char_cnt_o != 16'hFFFF)
        char_cnt_o <= char_cnt_o + 16'd1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    sh_n      = sh;
    par_bad_n = par_bad;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
    data_ld   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n   = START;
          cnt_n     = HALF;
          par_bad_n = 1'b0;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - ONE;
        end else if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          idx_n   = '0;
          cnt_n   = FULL;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - ONE;
        end else begin
          sh_n  = {rx_s, sh[7:1]};
          cnt_n = FULL;
          idx_n = idx + 3'd1;
          if (idx == 3'd7)
            state_n = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (!tick) begin
          cnt_n = cnt - ONE;
        end else begin
          par_bad_n = rx_s ^ (^sh) ^ PARITY_ODD;
          cnt_n     = FULL;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - ONE;
        end else begin
          data_ld = 1'b1;
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end else begin
            perr_n  = par_bad;
            valid_n = !par_bad;
            state_n = IDLE;
          end
        end
      end
      // a held-low line must rise before a new start counts
      BREAK: begin
        if (rx_s)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
